// File: rtl/serial_link_if.sv
// Byte-stream handshake and serial line bundle for serial_link.
// slave is the link endpoint; master is whatever feeds it and watches it.
interface serial_link_if #(
  parameter int DATA_W = 8
);
  logic              ready;
  logic              send;
  logic [DATA_W-1:0] data;
  logic              TX;
  logic              busy;
  logic              RX;
  logic              arrived;
  logic [DATA_W-1:0] dataO;
  logic              parity_err;
  logic              frame_err;

  modport slave (
    input  send, data, RX,
    output ready, TX, busy, arrived, dataO, parity_err, frame_err
  );

  modport master (
    output send, data, RX,
    input  ready, TX, busy, arrived, dataO, parity_err, frame_err
  );
endinterface

// File: rtl/serial_link.sv
// Full-duplex async serial endpoint: FIFO-fed transmitter plus a receiver with parity/stop checks.
// TX starts one edge after the FIFO has data; ready drops while the FIFO is full and pushes then are dropped.
module serial_link #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_link_if.slave  sl
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] D_LAST  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] S_LAST  = BW'(STOP_BITS - 1);
  localparam logic          HAS_PAR = (PARITY != 0);
  localparam logic          ODD     = (PARITY == 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push, pop;

  tx_state_e         tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_q, tx_d;

  logic              s1_q, s1_d, s2_q, s2_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_pbit_q, rx_pbit_d;
  logic              rx_ferr_q, rx_ferr_d;
  logic              arrived_q, arrived_d;
  logic [DATA_W-1:0] data_o_q, data_o_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              rs;

  assign sl.ready      = (count_q != (AW+1)'(FIFO_DEPTH));
  assign push          = sl.send & sl.ready;
  assign pop           = (tx_state_q == TX_IDLE) && (count_q != '0);
  assign sl.busy       = (count_q != '0) || (tx_state_q != TX_IDLE);
  assign sl.TX         = tx_q;
  assign sl.arrived    = arrived_q;
  assign sl.dataO      = data_o_q;
  assign sl.parity_err = parity_err_q;
  assign sl.frame_err  = frame_err_q;
  assign rs            = s2_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sl.data;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    if (tx_state_q == TX_IDLE) begin
      tx_d = 1'b1;
      if (count_q != '0) begin
        tx_state_d = TX_START;
        tx_shift_d = mem_q[rd_ptr_q];
        tx_par_d   = (^mem_q[rd_ptr_q]) ^ ODD;
        tx_cnt_d   = '0;
        tx_d       = 1'b0;
      end
    end else if (tx_cnt_q != C_LAST) begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end else begin
      // Bit boundary: the next bit's level is registered here so TX changes with the state.
      tx_cnt_d = '0;
      case (tx_state_q)
        TX_START: begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end
        TX_DATA: begin
          if (tx_bit_q != D_LAST) begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end else if (HAS_PAR) begin
            tx_state_d = TX_PAR;
            tx_d       = tx_par_q;
          end else begin
            tx_state_d = TX_STOP;
            tx_bit_d   = '0;
            tx_d       = 1'b1;
          end
        end
        TX_PAR: begin
          tx_state_d = TX_STOP;
          tx_bit_d   = '0;
          tx_d       = 1'b1;
        end
        TX_STOP: begin
          if (tx_bit_q != S_LAST) tx_bit_d = tx_bit_q + 1'b1;
          else                    tx_state_d = TX_IDLE;
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    s1_d         = sl.RX;
    s2_d         = s1_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_pbit_d    = rx_pbit_q;
    rx_ferr_d    = rx_ferr_q;
    arrived_d    = 1'b0;
    data_o_d     = data_o_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    case (rx_state_q)
      // A line stuck low after a frame must go high before another start bit is accepted.
      RX_ARM:  if (rs) rx_state_d = RX_IDLE;
      RX_IDLE: begin
        if (!rs) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q != H_LAST) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end else if (rs) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_ferr_d  = 1'b0;
        end
      end
      default: begin
        if (rx_cnt_q != C_LAST) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end else begin
          rx_cnt_d = '0;
          case (rx_state_q)
            RX_DATA: begin
              rx_shift_d = {rs, rx_shift_q[DATA_W-1:1]};
              if (rx_bit_q != D_LAST) begin
                rx_bit_d = rx_bit_q + 1'b1;
              end else begin
                rx_state_d = HAS_PAR ? RX_PAR : RX_STOP;
                rx_bit_d   = '0;
              end
            end
            RX_PAR: begin
              rx_pbit_d  = rs;
              rx_state_d = RX_STOP;
            end
            RX_STOP: begin
              rx_ferr_d = rx_ferr_q | ~rs;
              if (rx_bit_q != S_LAST) begin
                rx_bit_d = rx_bit_q + 1'b1;
              end else begin
                rx_state_d   = RX_ARM;
                arrived_d    = 1'b1;
                data_o_d     = rx_shift_q;
                frame_err_d  = rx_ferr_q | ~rs;
                parity_err_d = HAS_PAR & ((^rx_shift_q) ^ rx_pbit_q ^ ODD);
              end
            end
            default: rx_state_d = RX_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      tx_q         <= 1'b1;
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_pbit_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      arrived_q    <= 1'b0;
      data_o_q     <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      tx_q         <= tx_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_pbit_q    <= rx_pbit_d;
      rx_ferr_q    <= rx_ferr_d;
      arrived_q    <= arrived_d;
      data_o_q     <= data_o_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end
endmodule

// File: doc/serial_link.md
# serial_link

Parametrised full-duplex asynchronous serial link: a byte-oriented transmitter fed through a TX FIFO, plus an independent receiver with parity and framing checks. It is the next-generation serial endpoint of the alarm system. It generalises the fixed 8-bit send/ready/TX/arrived path to configurable word width, bit period, parity, stop bits and queue depth. TX and RX share one clock domain, so a bench can loop TX back to RX.

## Interface
- DATA_W, 8: payload bits per frame, legal 5..16
- CLKS_PER_BIT, 4: clock cycles per serial bit, legal ≥4
- PARITY, 0: 0 none, 1 even, 2 odd
- STOP_BITS, 1: 1 or 2
- FIFO_DEPTH, 4: TX queue entries, power of two, ≥2
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- ready  out  1  TX FIFO not full; combinational from FIFO count
- send  in  1  push request; `data` is written when send=1 and ready=1 at a rising edge
- data  in  DATA_W  word to transmit
- TX  out  1  serial output, registered, idle high
- busy  out  1  FIFO non-empty or transmitter not in IDLE
- RX  in  1  serial input, asynchronous to Clock
- arrived  out  1  one-cycle pulse: received word valid
- dataO  out  DATA_W  last received word, held until the next arrived
- parity_err  out  1  parity status of the last frame, updated with arrived; 0 when PARITY=0
- frame_err  out  1  stop-bit status of the last frame, updated with arrived

## Operation
- Frame format: start bit 0, DATA_W bits LSB first, optional parity bit, then STOP_BITS bits of 1. Each bit lasts CLKS_PER_BIT cycles. N = 1+DATA_W+(PARITY?1:0)+STOP_BITS.
- Even parity: XOR of data and parity bit = 0. Odd parity: that XOR = 1.
- TX FIFO:
  - A push with ready=0 is dropped; no state change.
  - A push and a pop on the same edge leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with count>0 at an edge: pop the head, load the shift register, enter START, drive TX←0.
  - Each state lasts CLKS_PER_BIT cycles, tracked by a bit counter and a cycle counter.
  - PARITY is skipped when PARITY=0.
  - After the last STOP bit the FSM returns to IDLE and holds TX=1 for at least one cycle.
- RX path:
  - RX passes through a 2-flop synchronizer; both flops reset to 1. rs denotes the synchronized value.
  - RX FSM states: ARM, IDLE, START, DATA, PARITY, STOP.
  - ARM: wait for rs=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
  - IDLE: when rs=0 in cycle s, start counting.
  - The start bit is sampled in cycle s+H, where H=CLKS_PER_BIT/2 (integer division). If that sample is 1, it is a false start: return to IDLE with no output.
  - Bit k (k=1..N-1) is sampled in cycle s+H+k·CLKS_PER_BIT.
  - After the last stop sample:
    - dataO takes the received word.
    - parity_err = parity mismatch.
    - frame_err = 1 if any stop sample was 0.
    - arrived=1 in cycle s+H+(N-1)·CLKS_PER_BIT+1.
    - The FSM goes to ARM.
  - A word is delivered even when an error flag is set.
- Reset values: TX=1, ready=1, busy=0, arrived=0, dataO=0, parity_err=0, frame_err=0. FIFO is empty, both FSMs are in IDLE, synchronizer flops are 1.
- Reset mid-operation:
  - TX returns to 1 asynchronously and queued words are lost.
  - A partial RX frame is discarded with no arrived pulse.

## Timing
- Push into an empty FIFO with the transmitter in IDLE at edge k: TX falls after edge k+1, i.e. first low cycle t0=k+1.
- Frame occupies N·CLKS_PER_BIT cycles. Back-to-back queued words are separated by exactly one idle-high cycle.
- ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees a slot.
- Loopback (RX=TX): s=t0+2, so arrived occurs at t0+3+H+(N-1)·CLKS_PER_BIT. Defaults (N=10, C=4, H=2): t0+41.
- busy falls in the first IDLE cycle after the last stop bit with the FIFO empty.

## Test plan
- Defaults, loopback, push 8'h42 after reset:
  - TX falls 1 cycle after the push edge.
  - Bit pattern is 0,0,1,0,0,0,0,1,0,1, each bit 4 cycles.
  - arrived pulses at t0+41 with dataO=8'h42 and both error flags 0.
- Burst of 6 words (8'hAA,45,72,F3,52,CE) with FIFO_DEPTH=4, pushing each time ready=1:
  - ready drops when the FIFO holds 4 words.
  - Every word arrives in order.
  - Frames are spaced N·C+1 cycles apart.
  - Pushes issued while ready=0 are dropped.
- PARITY=2, STOP_BITS=2, DATA_W=7, RX driven by the bench with a corrupted parity bit for 7'h0A: arrived with dataO=7'h0A, parity_err=1, frame_err=0.
- RX stop bit forced 0, then line held low for 3 frame times: exactly one arrived with frame_err=1; no further arrived until RX returns high.
- RX low glitch of 1 cycle: no arrived. Then a valid frame 8'h77: arrived with 8'h77.
- Reset asserted mid-frame during the DATA state:
  - TX=1, busy=0 and ready=1 immediately.
  - No arrived for the aborted frame.
  - After release, push 8'h6B: received correctly.
